// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate-array BIST controller: lane map, FSM states
// and the golden response per input pattern.
package gate_bist_pkg;

    localparam int N_LANES = 5;

    localparam int LANE_AND  = 0;
    localparam int LANE_OR   = 1;
    localparam int LANE_NOTA = 2;
    localparam int LANE_NAND = 3;
    localparam int LANE_NOR  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Golden y vector for pattern p = {a,b} with every lane driven identically.
    function automatic logic [N_LANES-1:0] gate_expected(input logic [1:0] p);
        logic                a;
        logic                b;
        logic [N_LANES-1:0]  y;
        a = p[1];
        b = p[0];
        y = '0;
        y[LANE_AND]  = a & b;
        y[LANE_OR]   = a | b;
        y[LANE_NOTA] = ~a;
        y[LANE_NAND] = ~(a & b);
        y[LANE_NOR]  = ~(a | b);
        return y;
    endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference of the gate array: per-lane expected y from the
// same a/b stimulus the controller drives into the real array.
module gate_golden_model
    import gate_bist_pkg::*;
(
    input  logic [N_LANES-1:0] a,
    input  logic [N_LANES-1:0] b,
    output logic [N_LANES-1:0] y
);

    assign y[LANE_AND]  = a[LANE_AND] & b[LANE_AND];
    assign y[LANE_OR]   = a[LANE_OR] | b[LANE_OR];
    assign y[LANE_NOTA] = ~a[LANE_NOTA];
    assign y[LANE_NAND] = ~(a[LANE_NAND] & b[LANE_NAND]);
    assign y[LANE_NOR]  = ~(a[LANE_NOR] | b[LANE_NOR]);

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer for the 5-lane gate array: walks the four {a,b} patterns,
// settles, checks y_obs against the golden model and keeps sticky results.
//
//  state | meaning
//  IDLE  | drives 0, waiting for start
//  APPLY | pattern p driven, settle counter running 0..SETTLE_CYC-1
//  CHECK | pattern p still driven, y_obs compared and results updated
//  DONE  | run complete, results held, drives 0
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic [N_LANES-1:0] a_drv,
    output logic [N_LANES-1:0] b_drv,
    input  logic [N_LANES-1:0] y_obs,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_LANES-1:0] fail_mask,
    output logic [1:0]         first_fail_pat
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t             state;
    state_t             state_n;
    logic [1:0]         p;
    logic [1:0]         p_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [N_LANES-1:0] fail_mask_n;
    logic [1:0]         first_fail_pat_n;
    logic               done_n;
    logic               busy_n;
    logic [N_LANES-1:0] a_drv_n;
    logic [N_LANES-1:0] b_drv_n;
    logic [N_LANES-1:0] exp_y;
    logic [N_LANES-1:0] mism;

    gate_golden_model u_golden (
        .a (a_drv),
        .b (b_drv),
        .y (exp_y)
    );

    // Case-equality so an X/Z on y_obs counts as a mismatch.
    always_comb begin
        mism = '0;
        for (int i = 0; i < N_LANES; i++) begin
            mism[i] = (y_obs[i] !== exp_y[i]);
        end
    end

    always_comb begin
        state_n          = state;
        p_n              = p;
        cnt_n            = cnt;
        fail_mask_n      = fail_mask;
        first_fail_pat_n = first_fail_pat;
        done_n           = done;

        case (state)
            IDLE, DONE: begin
                if (abort) begin
                    state_n = IDLE;
                    done_n  = 1'b0;
                    if (start) begin
                        fail_mask_n      = '0;
                        first_fail_pat_n = 2'd0;
                    end
                end else if (start) begin
                    state_n          = APPLY;
                    p_n              = 2'd0;
                    cnt_n            = '0;
                    fail_mask_n      = '0;
                    first_fail_pat_n = 2'd0;
                    done_n           = 1'b0;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_n = IDLE;
                    p_n     = 2'd0;
                    cnt_n   = '0;
                end else if (cnt == SETTLE_LAST) begin
                    state_n = CHECK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_n = IDLE;
                    p_n     = 2'd0;
                end else begin
                    fail_mask_n = fail_mask | mism;
                    if ((fail_mask == '0) && (mism != '0)) begin
                        first_fail_pat_n = p;
                    end
                    if (p == 2'd3) begin
                        state_n = DONE;
                        p_n     = 2'd0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = APPLY;
                        p_n     = p + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_n  = (state_n == APPLY) || (state_n == CHECK);
        a_drv_n = busy_n ? {N_LANES{p_n[1]}} : '0;
        b_drv_n = busy_n ? {N_LANES{p_n[0]}} : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            p              <= 2'd0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            a_drv          <= '0;
            b_drv          <= '0;
            fail_mask      <= '0;
            first_fail_pat <= 2'd0;
        end else begin
            state          <= state_n;
            p              <= p_n;
            cnt            <= cnt_n;
            busy           <= busy_n;
            done           <= done_n;
            a_drv          <= a_drv_n;
            b_drv          <= b_drv_n;
            fail_mask      <= fail_mask_n;
            first_fail_pat <= first_fail_pat_n;
        end
    end

    assign pass = done & (fail_mask == '0);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: a faultable gate array model feeds y_obs, and each
// run's results are predicted from the golden pattern table and the faults.
module tb_gate_bist_ctrl;

    localparam int SETTLE   = 2;
    localparam int BUSY_LEN = 4 * (SETTLE + 1);

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic [4:0] a_drv;
    logic [4:0] b_drv;
    logic [4:0] y_obs;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] fail_mask;
    logic [1:0] first_fail_pat;

    logic [4:0] sa0;
    logic [4:0] sa1;
    logic [4:0] array_y;
    logic [4:0] exp_tab [4];

    int checks;
    int errors;

    gate_bist_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .a_drv          (a_drv),
        .b_drv          (b_drv),
        .y_obs          (y_obs),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_mask      (fail_mask),
        .first_fail_pat (first_fail_pat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate array under test: healthy gates, then stuck-at faults overlaid.
    always_comb begin
        array_y    = '0;
        array_y[0] = a_drv[0] & b_drv[0];
        array_y[1] = a_drv[1] | b_drv[1];
        array_y[2] = ~a_drv[2];
        array_y[3] = ~(a_drv[3] & b_drv[3]);
        array_y[4] = ~(a_drv[4] | b_drv[4]);
    end
    assign y_obs = (array_y & ~sa0) | sa1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic predict(input logic [4:0] s0, input logic [4:0] s1,
                           output logic [4:0] fm, output logic [1:0] ffp);
        logic [4:0] m;
        fm  = '0;
        ffp = 2'd0;
        for (int p = 0; p < 4; p++) begin
            m = ((exp_tab[p] & ~s0) | s1) ^ exp_tab[p];
            if (fm == '0 && m != '0) ffp = 2'(p);
            fm |= m;
        end
    endtask

    task automatic run_test(input string name, input logic [4:0] s0, input logic [4:0] s1,
                            input int restart_at);
        logic [4:0] efm;
        logic [1:0] effp;
        logic [1:0] pat;
        int         cyc;
        sa0 = s0;
        sa1 = s1 & ~s0;
        predict(sa0, sa1, efm, effp);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({name, "_clr_fm"}, 32'(fail_mask), 32'd0);
        chk({name, "_done_lo"}, 32'(done), 32'd0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            pat = 2'(cyc / (SETTLE + 1));
            chk({name, "_a_drv"}, 32'(a_drv), 32'({5{pat[1]}}));
            chk({name, "_b_drv"}, 32'(b_drv), 32'({5{pat[0]}}));
            if (cyc == restart_at) start = 1'b1;
            tick();
            start = 1'b0;
            cyc++;
        end
        chk({name, "_busy_len"}, 32'(cyc), 32'(BUSY_LEN));
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_pass"}, 32'(pass), 32'(efm == '0));
        chk({name, "_fail_mask"}, 32'(fail_mask), 32'(efm));
        if (efm != '0) chk({name, "_first_pat"}, 32'(first_fail_pat), 32'(effp));
        chk({name, "_drv_idle"}, 32'({a_drv, b_drv}), 32'd0);
        tick();
        chk({name, "_done_hold"}, 32'(done), 32'd1);
        chk({name, "_busy_hold"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] s0;
        logic [4:0] s1;
        checks     = 0;
        errors     = 0;
        exp_tab[0] = 5'b11100;
        exp_tab[1] = 5'b01110;
        exp_tab[2] = 5'b01010;
        exp_tab[3] = 5'b00011;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        sa0   = '0;
        sa1   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fm", 32'(fail_mask), 32'd0);
        chk("rst_ffp", 32'(first_fail_pat), 32'd0);
        chk("rst_drv", 32'({a_drv, b_drv}), 32'd0);
        rst = 1'b0;
        tick();

        run_test("healthy", 5'b00000, 5'b00000, -1);
        run_test("lane2_sa0", 5'b00100, 5'b00000, -1);
        run_test("l0sa1_l4sa0", 5'b10000, 5'b00001, -1);
        run_test("restart_ignored", 5'b00100, 5'b00000, 4);

        // start+abort in DONE: abort wins and results clear
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_done", 32'(done), 32'd0);
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_fm", 32'(fail_mask), 32'd0);
        tick();
        chk("sa_stay_idle", 32'(busy), 32'd0);

        // async reset during APPLY of pattern 2
        sa0   = 5'b00100;
        sa1   = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("pre_rst_a_drv", 32'(a_drv), 32'h1f);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_drv", 32'({a_drv, b_drv}), 32'd0);
        chk("arst_fm", 32'(fail_mask), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_test("after_rst", 5'b00000, 5'b00000, -1);

        // abort at CHECK of pattern 1 with lane3 stuck-at-0
        sa0   = 5'b01000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_fm", 32'(fail_mask), 32'h08);
        chk("abort_ffp", 32'(first_fail_pat), 32'd0);
        chk("abort_drv", 32'({a_drv, b_drv}), 32'd0);
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        run_test("after_abort", 5'b00000, 5'b00000, -1);

        for (int n = 0; n < 20; n++) begin
            s0 = 5'($urandom) & 5'($urandom);
            s1 = 5'($urandom) & 5'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            run_test("rand", s0, s1, int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
